// File: rtl/kyber_pkg.sv
// ---------------------------------------------------------------------------
// kyber_pkg
// Shared Baby-Kyber definitions (Q=17, N=4, K=2) used by key generation,
// encryption and decryption.
//   Q, N, K        ring / module parameters
//   IN_W, OUT_W    signed input coefficient width, reduced coefficient width
//   DU, DV         compression widths for u and v
//   ACC_W          MAC accumulator width
//   coef_t, poly_t reduced coefficient and polynomial types
//   mod_q()        signed true modulo into [0,Q-1]
//   compress()     round(2^d*x/Q) mod 2^d, round half up
// ---------------------------------------------------------------------------
package kyber_pkg;

    localparam int Q      = 17;
    localparam int N      = 4;
    localparam int K      = 2;
    localparam int IN_W   = 32;
    localparam int OUT_W  = 5;
    localparam int DU     = 3;
    localparam int DV     = 2;
    localparam int HALF_Q = (Q + 1) / 2;

    // Worst case K*N products of (Q-1)^2 plus one added term, two bits headroom.
    localparam int ACC_W = $clog2(K * N * (Q - 1) * (Q - 1) + Q) + 2;

    localparam int NUM_OUT = (K + 1) * N;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int OW = $clog2(NUM_OUT);
    localparam int PW = $clog2(K + 1);

    typedef logic [OUT_W-1:0] coef_t;
    typedef coef_t [N-1:0] poly_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic coef_t mod_q(input logic signed [IN_W-1:0] x);
        logic signed [IN_W-1:0] rm;
        rm = x % Q;
        if (rm < 0) begin
            rm = rm + Q;
        end
        return rm[OUT_W-1:0];
    endfunction

    function automatic coef_t compress(input coef_t x, input int unsigned d);
        int unsigned num;
        num = (32'(x) << (d + 1)) + 32'(Q);
        return coef_t'((num / 32'(2 * Q)) % (32'd1 << d));
    endfunction

endpackage

// File: rtl/kyber_encrypt_core_mac.sv
// ---------------------------------------------------------------------------
// kyber_coef_mac
// Signed accumulator for one output coefficient: acc +/-= a*b.
//   clk, rst_n  clock, async active-low reset
//   clear       zero the accumulator (priority over en)
//   en          accumulate this cycle
//   a, b        reduced operands in [0,Q-1]
//   neg         subtract the product (negacyclic wrap term)
//   acc         running signed sum
// ---------------------------------------------------------------------------
module kyber_coef_mac
    import kyber_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    en,
    input  coef_t                   a,
    input  coef_t                   b,
    input  logic                    neg,
    output logic signed [ACC_W-1:0] acc
);

    logic [2*OUT_W-1:0]      prod;
    logic signed [ACC_W-1:0] term;

    always_comb begin
        prod = {{OUT_W{1'b0}}, a} * {{OUT_W{1'b0}}, b};
        term = {{(ACC_W - 2*OUT_W){1'b0}}, prod};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= neg ? (acc - term) : (acc + term);
        end
    end

endmodule

// File: rtl/kyber_encrypt_core.sv
// ---------------------------------------------------------------------------
// kyber_encrypt_core
// Baby-Kyber encryption: u = A^T*r + e1, v = t^T*r + e2 + msg*ceil(Q/2),
// computed one coefficient at a time on a single MAC (K*N MAC cycles plus
// one FINAL cycle per coefficient).
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    input bundle handshake (pk_a, pk_t, msg, r, e1, e2)
//   out_valid/out_ready  ciphertext handshake (ct_u, ct_v)
//   busy                 high in MAC/FINAL
// Build option: KYBER_ENC_COMPRESS_EN compresses u to DU bits and v to DV
// bits at FINAL; otherwise raw coefficients in [0,Q-1] are output.
//
// state | meaning
// IDLE  | waiting for an input bundle, in_ready=1
// MAC   | accumulating K*N products for output coefficient o
// FINAL | add noise/message, reduce, write output register, advance o
// DONE  | ciphertext presented until out_ready
// ---------------------------------------------------------------------------
module kyber_encrypt_core
    import kyber_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [K-1:0][K-1:0][N-1:0][IN_W-1:0]   pk_a,
    input  logic [K-1:0][N-1:0][IN_W-1:0]          pk_t,
    input  logic [N-1:0]                           msg,
    input  logic [K-1:0][N-1:0][IN_W-1:0]          r,
    input  logic [K-1:0][N-1:0][IN_W-1:0]          e1,
    input  logic [N-1:0][IN_W-1:0]                 e2,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output poly_t [K-1:0]                          ct_u,
    output poly_t                                  ct_v,
    output logic                                   busy
);

    state_t          state;
    logic [KW-1:0]   j;
    logic [NW-1:0]   m;
    logic [OW-1:0]   o;

    coef_t           cap_a  [K][K][N];
    coef_t           cap_t  [K][N];
    coef_t           cap_r  [K][N];
    coef_t           cap_e1 [K][N];
    coef_t           cap_e2 [N];
    logic [N-1:0]    cap_msg;

    logic            accept;
    logic [PW-1:0]   p;
    logic [NW-1:0]   c;
    logic [NW-1:0]   ridx;
    logic            is_u;
    coef_t           a_sel;
    coef_t           b_sel;
    coef_t           e_sel;
    logic            neg;
    logic signed [ACC_W-1:0] acc;
    logic signed [IN_W-1:0]  acc_ext;
    logic signed [IN_W-1:0]  e_ext;
    logic signed [IN_W-1:0]  h_ext;
    coef_t           fin_red;
    coef_t           fin_val;

    assign accept = in_valid && in_ready;

    always_comb begin
        p    = PW'(32'(o) / N);
        c    = NW'(32'(o) % N);
        is_u = (p < PW'(K));
        // N is a power of two, so NW-bit subtraction wraps mod N.
        ridx = c - m;
        neg  = (m > c);
        if (is_u) begin
            a_sel = cap_a[j][p[KW-1:0]][m];
            e_sel = cap_e1[p[KW-1:0]][c];
        end else begin
            a_sel = cap_t[j][m];
            e_sel = cap_e2[c];
        end
        b_sel   = cap_r[j][ridx];
        acc_ext = {{(IN_W - ACC_W){acc[ACC_W-1]}}, acc};
        e_ext   = {{(IN_W - OUT_W){1'b0}}, e_sel};
        h_ext   = (!is_u && cap_msg[c]) ? IN_W'(HALF_Q) : '0;
        fin_red = mod_q(acc_ext + e_ext + h_ext);
`ifdef KYBER_ENC_COMPRESS_EN
        fin_val = compress(fin_red, is_u ? DU : DV);
`else
        fin_val = fin_red;
`endif
    end

    kyber_coef_mac u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept || (state == S_FINAL)),
        .en    (state == S_MAC),
        .a     (a_sel),
        .b     (b_sel),
        .neg   (neg),
        .acc   (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            j         <= '0;
            m         <= '0;
            o         <= '0;
            ct_u      <= '0;
            ct_v      <= '0;
            cap_msg   <= '0;
            for (int x = 0; x < K; x++) begin
                for (int n = 0; n < N; n++) begin
                    for (int y = 0; y < K; y++) begin
                        cap_a[x][y][n] <= '0;
                    end
                    cap_t[x][n]  <= '0;
                    cap_r[x][n]  <= '0;
                    cap_e1[x][n] <= '0;
                end
            end
            for (int n = 0; n < N; n++) begin
                cap_e2[n] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        for (int x = 0; x < K; x++) begin
                            for (int n = 0; n < N; n++) begin
                                for (int y = 0; y < K; y++) begin
                                    cap_a[x][y][n] <= mod_q($signed(pk_a[x][y][n]));
                                end
                                cap_t[x][n]  <= mod_q($signed(pk_t[x][n]));
                                cap_r[x][n]  <= mod_q($signed(r[x][n]));
                                cap_e1[x][n] <= mod_q($signed(e1[x][n]));
                            end
                        end
                        for (int n = 0; n < N; n++) begin
                            cap_e2[n] <= mod_q($signed(e2[n]));
                        end
                        cap_msg  <= msg;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        j        <= '0;
                        m        <= '0;
                        o        <= '0;
                        state    <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (m == NW'(N - 1)) begin
                        m <= '0;
                        if (j == KW'(K - 1)) begin
                            j     <= '0;
                            state <= S_FINAL;
                        end else begin
                            j <= j + KW'(1);
                        end
                    end else begin
                        m <= m + NW'(1);
                    end
                end
                S_FINAL: begin
                    if (is_u) begin
                        ct_u[p[KW-1:0]][c] <= fin_val;
                    end else begin
                        ct_v[c] <= fin_val;
                    end
                    if (o == OW'(NUM_OUT - 1)) begin
                        o         <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        o     <= o + OW'(1);
                        state <= S_MAC;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kyber_encrypt_core.sv
module tb_kyber_encrypt_core;
    import kyber_pkg::*;

    localparam int LAT = (K + 1) * N * (K * N + 1);

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic in_ready;
    logic [K-1:0][K-1:0][N-1:0][IN_W-1:0] pk_a;
    logic [K-1:0][N-1:0][IN_W-1:0]        pk_t;
    logic [N-1:0]                         msg;
    logic [K-1:0][N-1:0][IN_W-1:0]        r;
    logic [K-1:0][N-1:0][IN_W-1:0]        e1;
    logic [N-1:0][IN_W-1:0]               e2;
    logic out_valid;
    logic out_ready;
    poly_t [K-1:0] ct_u;
    poly_t         ct_v;
    logic busy;

    kyber_encrypt_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pk_a      (pk_a),
        .pk_t      (pk_t),
        .msg       (msg),
        .r         (r),
        .e1        (e1),
        .e2        (e2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct_u      (ct_u),
        .ct_v      (ct_v),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        poly_t [K-1:0] u;
        poly_t         v;
        int            acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    logic prev_ov  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic poly_t pv(input int c0, input int c1, input int c2, input int c3);
        poly_t t;
        t[0] = coef_t'(c0);
        t[1] = coef_t'(c1);
        t[2] = coef_t'(c2);
        t[3] = coef_t'(c3);
        return t;
    endfunction

    // Scoreboard monitor: latency on out_valid rise, data on handshake.
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(LAT));
                end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("ct_u", 64'(ct_u), 64'(e.u));
                chk("ct_v", 64'(ct_v), 64'(e.v));
                done_cnt++;
            end
            prev_ov = out_valid;
        end
    end

    task automatic clear_ops();
        pk_a = '0;
        pk_t = '0;
        msg  = '0;
        r    = '0;
        e1   = '0;
        e2   = '0;
    endtask

    task automatic send(input poly_t eu0, input poly_t eu1, input poly_t ev);
        exp_t e;
        int   n;
        @(negedge clk);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e.u[0]    = eu0;
            e.u[1]    = eu1;
            e.v       = ev;
            e.acc_cyc = cyc;
            sb.push_back(e);
            in_valid = 1'b0;
            // Operands change after acceptance; the core must use its copy.
            pk_t[0][0] = 32'd7;
            r[1][2]    = 32'd1;
            msg        = ~msg;
        end
    endtask

    task automatic wait_out();
        int target;
        int n;
        target = done_cnt + 1;
        n = 0;
        while (done_cnt < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (done_cnt < target) begin
            chk("output_timeout", 64'd0, 64'd1);
        end
    endtask

    poly_t z, t1v, t2u0, t3v, t7u1, t7v, t8u0, t8u1, t8v;

    initial begin
        z = '0;
`ifdef KYBER_ENC_COMPRESS_EN
        t1v  = pv(2, 0, 2, 0);
        t2u0 = pv(0, 0, 0, 0);
        t3v  = pv(3, 0, 0, 0);
        t7u1 = pv(0, 1, 1, 0);
        t7v  = pv(2, 2, 2, 2);
        t8u0 = pv(0, 0, 0, 6);
        t8u1 = pv(0, 0, 0, 0);
        t8v  = pv(0, 0, 0, 3);
`else
        t1v  = pv(9, 0, 9, 0);
        t2u0 = pv(16, 0, 0, 0);
        t3v  = pv(14, 16, 0, 0);
        t7u1 = pv(16, 2, 3, 0);
        t7v  = pv(9, 9, 9, 9);
        t8u0 = pv(0, 0, 0, 12);
        t8u1 = pv(1, 0, 0, 0);
        t8v  = pv(0, 0, 0, 11);
`endif
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clear_ops();
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ct_u", 64'(ct_u), 64'd0);
        chk("rst_ct_v", 64'(ct_v), 64'd0);
        rst_n = 1'b1;

        // Test 1: all zero, msg=0101.
        clear_ops();
        msg = 4'b0101;
        send(z, z, t1v);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_in_ready_low", 64'(in_ready), 64'd0);
        wait_out();

        // Test 2: A[0][0]=x^3, r[0]=x -> negacyclic wrap.
        clear_ops();
        pk_a[0][0][3] = 32'd1;
        r[0][1]       = 32'd1;
        send(t2u0, z, z);
        wait_out();

        // Test 3 with backpressure (test 4).
        clear_ops();
        pk_t[0][0] = -32'sd3;
        r[0][0]    = 32'd1;
        e2[1]      = -32'sd1;
        out_ready  = 1'b0;
        send(z, z, t3v);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_ct_v", 64'(ct_v), 64'(t3v));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("hs_in_ready", 64'(in_ready), 64'd1);
        chk("hs_out_valid", 64'(out_valid), 64'd0);
        // Back-to-back bundle right after hand-off.
        clear_ops();
        msg = 4'b0101;
        send(z, z, t1v);
        wait_out();

        // Test 7: e1 wraps (-1 -> 16, 20 -> 3), msg all ones.
        clear_ops();
        e1[1][0] = -32'sd1;
        e1[1][1] = 32'd2;
        e1[1][2] = 32'd20;
        msg      = 4'b1111;
        send(z, t7u1, t7v);
        wait_out();

        // Test 8: transpose and j=1 terms with wrap.
        clear_ops();
        pk_a[1][0][0] = 32'd5;
        pk_a[0][1][0] = 32'd1;
        pk_a[1][1][1] = 32'd1;
        r[1][3]       = -32'sd1;
        pk_t[1][0]    = 32'd3;
        e2[3]         = 32'd5;
        msg           = 4'b1000;
        send(t8u0, t8u1, t8v);
        wait_out();

        // Test 5: reset in the middle of MAC, then a fresh bundle.
        clear_ops();
        pk_a[0][0][3] = 32'd1;
        r[0][1]       = 32'd1;
        send(t2u0, z, z);
        repeat (49) @(posedge clk);
        #2;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_ct_u", 64'(ct_u), 64'd0);
        chk("mid_rst_ct_v", 64'(ct_v), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        clear_ops();
        pk_a[0][0][3] = 32'd1;
        r[0][1]       = 32'd1;
        send(t2u0, z, z);
        wait_out();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
